// File: rtl/id_stage.sv
// id_stage: decode stage; one-entry stage register, hazard stall, operand select, branch resolve.
// Ports: in_valid/in_ready/if_pc/inst_sram_rdata from fetch; br_taken/br_target redirect fetch;
// rf_raddr*/rf_rdata* register-file read; ex/mem/wb_dest (+ex_is_load, *_result) from downstream;
// out_valid/out_ready plus out_pc/out_inst/out_src1/out_src2/out_imm/out_dest bundle to EX.
// Build macro ID_BYPASS_EN: forward EX > MEM > WB results, stall only on EX load-use.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] inst_sram_rdata,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [4:0]  ex_dest,
  input  logic [4:0]  mem_dest,
  input  logic [4:0]  wb_dest,
  input  logic        ex_is_load,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_src1,
  output logic [31:0] out_src2,
  output logic [31:0] out_imm,
  output logic [4:0]  out_dest
);

  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;

  logic [5:0] op;
  logic [4:0] rj, rk, rd;
  logic is_add, is_sub, is_addi, is_lu12i, is_ld, is_st;
  logic is_b, is_bl, is_jirl;
  logic is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu, is_cbr;
  logic use1, use2;
  logic stall, ready_go, fire, cond;
  logic eq, lt, ltu;

  assign op = inst[31:26];
  assign rj = inst[9:5];
  assign rk = inst[14:10];
  assign rd = inst[4:0];

  assign is_add   = inst[31:15] == 17'h00020;
  assign is_sub   = inst[31:15] == 17'h00022;
  assign is_addi  = inst[31:22] == 10'h00a;
  assign is_lu12i = inst[31:25] == 7'h0a;
  assign is_ld    = inst[31:22] == 10'h0a2;
  assign is_st    = inst[31:22] == 10'h0a6;
  assign is_jirl  = op == 6'h13;
  assign is_b     = op == 6'h14;
  assign is_bl    = op == 6'h15;
  assign is_beq   = op == 6'h16;
  assign is_bne   = op == 6'h17;
  assign is_blt   = op == 6'h18;
  assign is_bge   = op == 6'h19;
  assign is_bltu  = op == 6'h1a;
  assign is_bgeu  = op == 6'h1b;
  assign is_cbr   = is_beq | is_bne | is_blt | is_bge | is_bltu | is_bgeu;

  // conditional branches and stores read rd as their second operand
  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_cbr | is_st) ? rd : rk;

  assign use1 = is_add | is_sub | is_addi | is_ld | is_st | is_jirl | is_cbr;
  assign use2 = is_add | is_sub | is_st | is_cbr;

  always_comb begin
    out_imm = 32'h0;
    unique case (1'b1)
      is_addi | is_ld | is_st: out_imm = {{20{inst[21]}}, inst[21:10]};
      is_lu12i:                out_imm = {inst[24:5], 12'h0};
      is_jirl | is_cbr:        out_imm = {{14{inst[25]}}, inst[25:10], 2'b0};
      is_b | is_bl:            out_imm = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0};
      default:                 out_imm = 32'h0;
    endcase
  end

  always_comb begin
    out_dest = 5'd0;
    if (is_bl)
      out_dest = 5'd1;
    else if (is_add | is_sub | is_addi | is_lu12i | is_ld | is_jirl)
      out_dest = rd;
  end

  // a zero source address never matches, so r0 cannot hazard
  logic ex1, mem1, wb1, ex2, mem2, wb2;
  assign ex1  = (|rf_raddr1) & (rf_raddr1 == ex_dest);
  assign mem1 = (|rf_raddr1) & (rf_raddr1 == mem_dest);
  assign wb1  = (|rf_raddr1) & (rf_raddr1 == wb_dest);
  assign ex2  = (|rf_raddr2) & (rf_raddr2 == ex_dest);
  assign mem2 = (|rf_raddr2) & (rf_raddr2 == mem_dest);
  assign wb2  = (|rf_raddr2) & (rf_raddr2 == wb_dest);

`ifdef ID_BYPASS_EN
  always_comb begin
    out_src1 = rf_rdata1;
    if (ex1)       out_src1 = ex_result;
    else if (mem1) out_src1 = mem_result;
    else if (wb1)  out_src1 = wb_result;
  end

  always_comb begin
    out_src2 = rf_rdata2;
    if (ex2)       out_src2 = ex_result;
    else if (mem2) out_src2 = mem_result;
    else if (wb2)  out_src2 = wb_result;
  end

  // a load in EX has no result yet
  assign stall = ex_is_load & ((use1 & ex1) | (use2 & ex2));
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_result, wb_result, ex_is_load};
  assign out_src1 = rf_rdata1;
  assign out_src2 = rf_rdata2;
  assign stall = (use1 & (ex1 | mem1 | wb1)) | (use2 & (ex2 | mem2 | wb2));
`endif

  assign ready_go  = ~stall;
  assign out_valid = valid & ready_go;
  assign in_ready  = ~valid | (ready_go & out_ready);
  assign fire      = out_valid & out_ready;

  assign eq  = out_src1 == out_src2;
  assign lt  = $signed(out_src1) < $signed(out_src2);
  assign ltu = out_src1 < out_src2;

  assign cond = is_b | is_bl | is_jirl
              | (is_beq & eq) | (is_bne & ~eq)
              | (is_blt & lt) | (is_bge & ~lt)
              | (is_bltu & ltu) | (is_bgeu & ~ltu);

  // no redirect while reset is being applied
  assign br_taken  = fire & cond & ~rst;
  assign br_target = (is_jirl ? out_src1 : pc) + out_imm;

  assign out_pc   = pc;
  assign out_inst = inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= 32'h0;
    end else if (in_ready) begin
      // the instruction behind a taken branch is on the wrong path
      valid <= in_valid & ~br_taken;
      if (in_valid & ~br_taken) begin
        pc   <= if_pc;
        inst <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage with hand-computed expectations.
// Default build checks stalling; ID_BYPASS_EN build checks forwarding instead.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic        ex_is_load;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_inst, out_src1, out_src2, out_imm;
  logic [4:0]  out_dest;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_imm(out_imm), .out_dest(out_dest)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e3r(input logic [16:0] o, input logic [4:0] k, j, d);
    return {o, k, j, d};
  endfunction

  function automatic logic [31:0] e12(input logic [9:0] o, input logic [11:0] s, input logic [4:0] j, d);
    return {o, s, j, d};
  endfunction

  function automatic logic [31:0] e16(input logic [5:0] o, input logic [15:0] s, input logic [4:0] j, d);
    return {o, s, j, d};
  endfunction

  function automatic logic [31:0] e26(input logic [5:0] o, input logic [25:0] s);
    return {o, s[15:0], s[25:16]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // offer one instruction for one edge, then withdraw it
  task automatic issue(input logic [31:0] p, input logic [31:0] w);
    in_valid = 1'b1;
    if_pc = p;
    inst_sram_rdata = w;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    if_pc = 32'h0;
    inst_sram_rdata = 32'h0;
    rf_rdata1 = 32'h0;
    rf_rdata2 = 32'h0;
    ex_dest = 5'd0;
    mem_dest = 5'd0;
    wb_dest = 5'd0;
    ex_is_load = 1'b0;
    ex_result = 32'h0;
    mem_result = 32'h0;
    wb_result = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_br_taken", {31'h0, br_taken}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_dest", {27'h0, out_dest}, 32'h0);
    rst = 1'b0;

    // addi.w r4,r0,5
    issue(32'h1c000000, e12(10'h00a, 12'd5, 5'd0, 5'd4));
    chk("addi_valid", {31'h0, out_valid}, 32'h1);
    chk("addi_pc", out_pc, 32'h1c000000);
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_dest", {27'h0, out_dest}, 32'h4);

    // beq r1,r2,+16 taken; the instruction offered alongside is dropped
    rf_rdata1 = 32'h7;
    rf_rdata2 = 32'h7;
    issue(32'h1c000004, e16(6'h16, 16'h0004, 5'd1, 5'd2));
    in_valid = 1'b1;
    if_pc = 32'h1c000008;
    inst_sram_rdata = e3r(17'h00020, 5'd3, 5'd4, 5'd5);
    #1;
    chk("beq_taken", {31'h0, br_taken}, 32'h1);
    chk("beq_target", br_target, 32'h1c000014);
    chk("beq_raddr2", {27'h0, rf_raddr2}, 32'h2);
    chk("beq_dest", {27'h0, out_dest}, 32'h0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("beq_drop", {31'h0, out_valid}, 32'h0);

    // blt signed not taken, then bltu unsigned taken back to back
    rf_rdata1 = 32'h5;
    rf_rdata2 = 32'hffffffff;
    issue(32'h1c000020, e16(6'h18, 16'hfffe, 5'd1, 5'd2));
    chk("blt_taken", {31'h0, br_taken}, 32'h0);
    chk("blt_imm", out_imm, 32'hfffffff8);
    issue(32'h1c000024, e16(6'h1a, 16'hfffe, 5'd1, 5'd2));
    chk("bltu_valid", {31'h0, out_valid}, 32'h1);
    chk("bltu_taken", {31'h0, br_taken}, 32'h1);
    chk("bltu_target", br_target, 32'h1c00001c);
    tick();

    // b -1 word, bl with a high offs26 bit
    issue(32'h1c000100, e26(6'h14, 26'h3ffffff));
    chk("b_taken", {31'h0, br_taken}, 32'h1);
    chk("b_target", br_target, 32'h1c0000fc);
    chk("b_dest", {27'h0, out_dest}, 32'h0);
    tick();
    issue(32'h1c000200, e26(6'h15, 26'h0010000));
    chk("bl_imm", out_imm, 32'h00040000);
    chk("bl_target", br_target, 32'h1c040200);
    chk("bl_dest", {27'h0, out_dest}, 32'h1);
    tick();

    // lu12i.w r7,0x12345 and st.w r3,r2,-4
    issue(32'h1c000300, {7'h0a, 20'h12345, 5'd7});
    chk("lu12i_imm", out_imm, 32'h12345000);
    chk("lu12i_dest", {27'h0, out_dest}, 32'h7);
    rf_rdata2 = 32'hcafe0001;
    issue(32'h1c000304, e12(10'h0a6, 12'hffc, 5'd2, 5'd3));
    chk("st_raddr1", {27'h0, rf_raddr1}, 32'h2);
    chk("st_raddr2", {27'h0, rf_raddr2}, 32'h3);
    chk("st_imm", out_imm, 32'hfffffffc);
    chk("st_dest", {27'h0, out_dest}, 32'h0);
    chk("st_src2", out_src2, 32'hcafe0001);

    // add.w r5,r4,r3 with r4 in flight
    rf_rdata1 = 32'h11;
    ex_result = 32'haa;
    mem_result = 32'hbb;
    wb_result = 32'hcc;
    ex_dest = 5'd4;
`ifdef ID_BYPASS_EN
    issue(32'h1c000308, e3r(17'h00020, 5'd3, 5'd4, 5'd5));
    chk("fwd_ex_valid", {31'h0, out_valid}, 32'h1);
    chk("fwd_ex_src1", out_src1, 32'haa);
    ex_is_load = 1'b1;
    issue(32'h1c00030c, e3r(17'h00020, 5'd3, 5'd4, 5'd5));
    chk("lu_stall_valid", {31'h0, out_valid}, 32'h0);
    chk("lu_stall_ready", {31'h0, in_ready}, 32'h0);
    tick();
    ex_is_load = 1'b0;
    ex_dest = 5'd0;
    mem_dest = 5'd4;
    #1;
    chk("lu_mem_valid", {31'h0, out_valid}, 32'h1);
    chk("lu_mem_src1", out_src1, 32'hbb);
    mem_dest = 5'd0;
`else
    issue(32'h1c000308, e3r(17'h00020, 5'd3, 5'd4, 5'd5));
    chk("hz_ex_valid", {31'h0, out_valid}, 32'h0);
    chk("hz_ex_ready", {31'h0, in_ready}, 32'h0);
    tick();
    ex_dest = 5'd0;
    mem_dest = 5'd4;
    #1;
    chk("hz_mem_valid", {31'h0, out_valid}, 32'h0);
    tick();
    mem_dest = 5'd0;
    wb_dest = 5'd4;
    #1;
    chk("hz_wb_ready", {31'h0, in_ready}, 32'h0);
    tick();
    wb_dest = 5'd0;
    #1;
    chk("hz_clear_valid", {31'h0, out_valid}, 32'h1);
    chk("hz_clear_src1", out_src1, 32'h11);
    chk("hz_clear_dest", {27'h0, out_dest}, 32'h5);
`endif

    // jirl r1,r6,1 held by out_ready=0, then fires
    rf_rdata1 = 32'h1c000100;
    issue(32'h1c000400, e16(6'h13, 16'h0001, 5'd6, 5'd1));
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
      chk("hold_br", {31'h0, br_taken}, 32'h0);
      chk("hold_pc", out_pc, 32'h1c000400);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("jirl_taken", {31'h0, br_taken}, 32'h1);
    chk("jirl_target", br_target, 32'h1c000104);
    chk("jirl_dest", {27'h0, out_dest}, 32'h1);
    chk("jirl_raddr1", {27'h0, rf_raddr1}, 32'h6);

    // reset while the branch is pending
    rst = 1'b1;
    #1;
    chk("rst_no_redirect", {31'h0, br_taken}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_drop_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_drop_ready", {31'h0, in_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  fetch stage holds valid instruction.
REQ-004 in_ready  out  1  id_stage accepts instruction this cycle.
REQ-005 if_pc  in  32  PC of offered instruction.
REQ-006 inst_sram_rdata  in  32  instruction word aligned with if_pc.
REQ-007 br_taken  out  1  redirect fetch this cycle.
REQ-008 br_target  out  32  redirect address.
REQ-009 rf_raddr1 / rf_raddr2  out  5 each  register-file read addresses (combinational).
REQ-010 rf_rdata1 / rf_rdata2  in  32 each  register-file read data, same cycle.
REQ-011 ex_dest / mem_dest / wb_dest  in  5 each  destination of downstream stage; 0 = no write.
REQ-012 ex_is_load  in  1  EX instruction is ld.w.
REQ-013 ex_result / mem_result / wb_result  in  32 each  downstream results (used only with bypass).
REQ-014 out_valid  out  1  decoded bundle valid.
REQ-015 out_ready  in  1  EX accepts bundle.
REQ-016 out_pc, out_inst, out_src1, out_src2, out_imm  out  32 each  bundle fields.
REQ-017 out_dest  out  5  write-back register; 0 when no write.

Function
REQ-018 Stage register {valid, pc, inst} SHALL load on in_valid & in_ready; valid clears when bundle leaves with no new arrival.
REQ-019 ready_go = ~stall; out_valid = valid & ready_go; in_ready = ~valid | (ready_go & out_ready); fire = out_valid & out_ready.
REQ-020 Fields: rj=inst[9:5], rk=inst[14:10], rd=inst[4:0]; rf_raddr1=rj; rf_raddr2=rd for beq/bne/blt/bge/bltu/bgeu/st.w, else rk.
REQ-021 Decoded set: add.w, sub.w, addi.w, lu12i.w, ld.w, st.w, b(0x14), bl(0x15), jirl(0x13), beq(0x16), bne(0x17), blt(0x18), bge(0x19), bltu(0x1A), bgeu(0x1B) (opcode = inst[31:26]); others pass with out_dest=0.
REQ-022 out_imm: si12 sign-extended (addi.w, ld.w, st.w); {si20,12'b0} (lu12i.w); sext(offs16)<<2 (jirl, cond. branches); sext({inst[9:0],inst[25:10]})<<2 (b, bl).
REQ-023 out_dest = 1 for bl; 0 for st.w, b and conditional branches; else rd.
REQ-024 Source hazard: a used source reg, nonzero, equal to a nonzero ex_dest/mem_dest/wb_dest; r0 never hazards.
REQ-025 Branch condition: beq/bne equality; blt/bge signed; bltu/bgeu unsigned; b/bl/jirl unconditional.
REQ-026 br_target = pc + out_imm, or src1 + out_imm for jirl; all arithmetic mod 2^32.
REQ-027 br_taken SHALL assert only when fire and condition true; never when stalled or out_ready low.
REQ-028 If fetch handshake coincides with br_taken, incoming instruction SHALL be discarded (valid loads 0).
REQ-029 out_src1/out_src2 = resolved operand values; out_pc/out_inst = stage register.
REQ-030 Simultaneous bundle departure and arrival SHALL be lossless; throughput one per cycle without hazards.

Reset
REQ-031 On rst: valid=0, pc=0, inst=0; hence out_valid=0, br_taken=0, in_ready=1, out_dest=0.
REQ-032 rst mid-stall or mid-branch SHALL discard held instruction; no redirect in reset cycle.

Configuration
REQ-033 Macro ID_BYPASS_EN defined: operands forwarded with priority EX > MEM > WB > register file; stall only when ex_is_load and hazard matches ex_dest.
REQ-034 ID_BYPASS_EN undefined: no forwarding; stall while any hazard exists against EX, MEM or WB; *_result inputs ignored.

Verification
REQ-035 rst 2 cycles, then in_valid=1, if_pc=0x1C000000, inst=addi.w r4,r0,5 -> next cycle out_valid=1, out_pc=0x1C000000, out_imm=5, out_dest=4.
REQ-036 beq r1,r2 offs16=4, rf_rdata1=rf_rdata2=7, out_ready=1, if_pc=0x1C000004 offered -> br_taken=1, br_target=pc+0x10, offered instruction dropped.
REQ-037 add.w r5,r4,r3 while ex_dest=4 -> without macro stalled until ex/mem/wb_dest clear of 4 (in_ready=0); with macro out_src1=ex_result same cycle.
REQ-038 With macro, ex_is_load=1, ex_dest=4, consumer of r4 -> exactly one stall cycle, then out_src1=mem_result.
REQ-039 out_ready=0 for 3 cycles with valid bundle -> bundle fields stable, in_ready=0, br_taken=0; jirl r1,r6,1 with r6=0x1C000100 then fires -> br_target=0x1C000104, out_dest=1.
